// File: rtl/iscas_bist_pkg.sv
// Shared state encoding, default polynomial/seed and the Galois step used by
// both the pattern LFSR and the response MISR.
package iscas_bist_pkg;

    localparam int unsigned SIG_MAX  = 64;
    localparam logic [15:0] DEF_POLY = 16'h002D;
    localparam logic [15:0] DEF_SEED = 16'h0001;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN,
        DONE
    } bist_state_e;

    // One Galois shift of a w-bit register kept in the low bits of x.
    function automatic logic [SIG_MAX-1:0] sig_step(
        input logic [SIG_MAX-1:0] x,
        input logic [SIG_MAX-1:0] poly,
        input int unsigned        w
    );
        logic [SIG_MAX-1:0] mask;
        logic               msb;
        mask = {SIG_MAX{1'b1}} >> (SIG_MAX - w);
        msb  = |(x & (SIG_MAX'(1) << (w - 1)));
        return ((x << 1) & mask) ^ (msb ? (poly & mask) : '0);
    endfunction

endpackage

// File: rtl/iscas_sig_reg.sv
// Signature register: Galois shift with XOR-in data, usable as LFSR (data
// tied to zero) or MISR. Load wins over enable.
module iscas_sig_reg
    import iscas_bist_pkg::*;
#(
    parameter int unsigned      SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [SIG_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic [SIG_W-1:0] i_din,
    output logic [SIG_W-1:0] o_q,
    output logic [SIG_W-1:0] o_next_c
);

    logic [SIG_W-1:0] r_q;
    logic [SIG_W-1:0] w_step;

    assign w_step = SIG_W'(sig_step(SIG_MAX'(r_q), SIG_MAX'(POLY), SIG_W));

    always_comb begin
        o_next_c = r_q;
        if (i_load) begin
            o_next_c = i_load_val;
        end else if (i_en) begin
            o_next_c = w_step ^ i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= o_next_c;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/iscas_bist_ctrl.sv
// BIST sequencer for small ISCAS sequential benchmarks: init vector, LFSR
// patterns, latency-aligned MISR compaction and golden compare.
module iscas_bist_ctrl
    import iscas_bist_pkg::*;
#(
    parameter int unsigned      N_IN        = 3,
    parameter int unsigned      N_OUT       = 6,
    parameter int unsigned      SIG_W       = 16,
    parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED        = SIG_W'(DEF_SEED),
    parameter int unsigned      PATTERNS    = 1024,
    parameter int unsigned      INIT_CYCLES = 2,
    parameter logic [N_IN-1:0]  INIT_VEC    = N_IN'(1),
    parameter int unsigned      CAPTURE_LAT = 1
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] golden,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam logic [SIG_W-1:0] SEED_EFF = (SEED == '0) ? SIG_W'(1) : SEED;
    localparam int unsigned CNT_A = (PATTERNS > INIT_CYCLES) ? PATTERNS : INIT_CYCLES;
    localparam int unsigned CNT_MAX = (CNT_A > CAPTURE_LAT) ? CNT_A : CAPTURE_LAT;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    bist_state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [N_IN-1:0]        r_dut_in, w_dut_in_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_pass, w_pass_nxt;
    logic [CAPTURE_LAT-1:0] r_pipe, w_pipe_nxt;
    logic                   w_lfsr_load, w_lfsr_en, w_misr_load, w_misr_en;
    logic                   w_pipe_clr, w_abort;
    logic [SIG_W-1:0]       w_lfsr, w_lfsr_next, w_misr, w_misr_next;
    logic                   w_unused_lfsr;

    assign w_abort   = abort & r_busy;
    // Capture only while a run is live, so an abort freezes the partial signature.
    assign w_misr_en = r_pipe[CAPTURE_LAT-1] & r_busy & ~abort;
    assign w_unused_lfsr = ^{w_lfsr[SIG_W-1:N_IN], w_lfsr_next};

    iscas_sig_reg #(.SIG_W(SIG_W), .POLY(POLY), .RST_VAL(SEED_EFF)) u_lfsr (
        .i_clk      (CK),
        .i_rst      (RST),
        .i_load     (w_lfsr_load),
        .i_load_val (SEED_EFF),
        .i_en       (w_lfsr_en),
        .i_din      ('0),
        .o_q        (w_lfsr),
        .o_next_c   (w_lfsr_next)
    );

    iscas_sig_reg #(.SIG_W(SIG_W), .POLY(POLY), .RST_VAL('0)) u_misr (
        .i_clk      (CK),
        .i_rst      (RST),
        .i_load     (w_misr_load),
        .i_load_val ('0),
        .i_en       (w_misr_en),
        .i_din      (SIG_W'(dut_out)),
        .o_q        (w_misr),
        .o_next_c   (w_misr_next)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dut_in_nxt = r_dut_in;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_pass_nxt   = r_pass;
        w_lfsr_load  = 1'b0;
        w_lfsr_en    = 1'b0;
        w_misr_load  = 1'b0;
        w_pipe_clr   = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt  = INIT;
                    w_cnt_nxt    = '0;
                    w_dut_in_nxt = INIT_VEC;
                    w_busy_nxt   = 1'b1;
                    w_done_nxt   = 1'b0;
                    w_pass_nxt   = 1'b0;
                    w_lfsr_load  = 1'b1;
                    w_misr_load  = 1'b1;
                    w_pipe_clr   = 1'b1;
                end
            end
            INIT: begin
                if (r_cnt == CNT_W'(INIT_CYCLES - 1)) begin
                    w_state_nxt  = RUN;
                    w_cnt_nxt    = '0;
                    w_dut_in_nxt = w_lfsr[N_IN-1:0];
                    w_lfsr_en    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                w_lfsr_en = 1'b1;
                if (r_cnt == CNT_W'(PATTERNS - 1)) begin
                    w_state_nxt  = DRAIN;
                    w_cnt_nxt    = '0;
                    w_dut_in_nxt = '0;
                end else begin
                    w_cnt_nxt    = r_cnt + CNT_W'(1);
                    w_dut_in_nxt = w_lfsr[N_IN-1:0];
                end
            end
            DRAIN: begin
                // The last capture lands on this same edge, so compare its result.
                if (r_cnt == CNT_W'(CAPTURE_LAT - 1)) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_misr_next == golden);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_cnt_nxt    = '0;
                w_dut_in_nxt = '0;
                w_busy_nxt   = 1'b0;
            end
        endcase
        if (w_abort) begin
            w_state_nxt  = IDLE;
            w_cnt_nxt    = '0;
            w_dut_in_nxt = '0;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b0;
            w_pass_nxt   = 1'b0;
            w_lfsr_en    = 1'b0;
            w_pipe_clr   = 1'b1;
        end
    end

    assign w_pipe_nxt = w_pipe_clr ? '0 : CAPTURE_LAT'({r_pipe, (r_state == RUN)});

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dut_in <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_pipe   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dut_in <= w_dut_in_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_pass   <= w_pass_nxt;
            r_pipe   <= w_pipe_nxt;
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = w_misr;

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
// Randomised scoreboard bench for iscas_bist_ctrl: a run-level model predicts
// the applied vectors, the compacted signature and the pass flag.
module tb_iscas_bist_ctrl;

    localparam int          N_IN        = 3;
    localparam int          N_OUT       = 6;
    localparam int          SIG_W       = 16;
    localparam logic [15:0] POLY        = 16'h002D;
    localparam logic [15:0] SEED        = 16'hE001;
    localparam int          PATTERNS    = 20;
    localparam int          INIT_CYCLES = 3;
    localparam logic [2:0]  INIT_VEC    = 3'b001;
    localparam int          CAPTURE_LAT = 2;
    localparam int          T_RUN       = INIT_CYCLES + PATTERNS + CAPTURE_LAT;

    typedef enum logic [1:0] {K_CYC, K_DONE, K_ABT} kind_e;
    typedef struct {
        kind_e       kind;
        logic [2:0]  din;
        logic [15:0] sig;
        logic        pass;
    } exp_t;

    exp_t exp_q[$];

    logic              CK = 1'b0;
    logic              RST;
    logic              start;
    logic              abort;
    logic [SIG_W-1:0]  golden;
    logic [N_OUT-1:0]  dut_out;
    logic [N_IN-1:0]   dut_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;

    int n_vec  = 0;
    int n_miss = 0;

    iscas_bist_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED),
        .PATTERNS(PATTERNS), .INIT_CYCLES(INIT_CYCLES), .INIT_VEC(INIT_VEC),
        .CAPTURE_LAT(CAPTURE_LAT)
    ) u_dut (
        .CK(CK), .RST(RST), .start(start), .abort(abort), .golden(golden),
        .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done),
        .pass(pass), .signature(signature)
    );

    always #5 CK = ~CK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // x^16+x^5+x^3+x^2+1 Galois shift, straight from the step rule.
    function automatic logic [15:0] mstep(input logic [15:0] x);
        return (x << 1) ^ (x[15] ? POLY : 16'h0000);
    endfunction

    // Monitor: pops one expectation per busy cycle and one at each run end.
    logic        prev_busy = 1'b0;
    logic        held_v    = 1'b0;
    logic [15:0] held_sig;
    logic        held_pass;

    always @(negedge CK) begin
        exp_t e;
        if (busy) begin
            held_v = 1'b0;
            if (exp_q.size() == 0) begin
                check("busy_unexpected", 32'(busy), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("busy_cycle", 32'({(e.kind == K_CYC), done, dut_in}), 32'({1'b1, 1'b0, e.din}));
            end
        end else begin
            if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    check("end_unexpected", 32'(done), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("end_kind", 32'(done), 32'(e.kind == K_DONE));
                    if (e.kind == K_DONE) begin
                        check("signature", 32'(signature), 32'(e.sig));
                        check("pass", 32'(pass), 32'(e.pass));
                        held_v    = 1'b1;
                        held_sig  = e.sig;
                        held_pass = e.pass;
                    end else begin
                        check("abort_flags", 32'({done, pass}), 32'(0));
                    end
                end
            end else if (held_v) begin
                check("done_hold", 32'({done, pass, signature}), 32'({1'b1, held_pass, held_sig}));
            end else begin
                check("idle_done", 32'(done), 32'(0));
            end
            check("idle_din", 32'(dut_in), 32'(0));
        end
        prev_busy = busy;
    end

    // One run: model the vectors and signature, push expectations, then drive.
    task automatic do_run(input bit echo, input bit good_gold, input int stop_at,
                          input bit use_rst, input bit noise);
        logic [2:0]  din_m  [T_RUN];
        logic [5:0]  dout_m [T_RUN+1];
        logic [15:0] lf;
        logic [15:0] sig;
        logic [15:0] gold;
        int          last;
        lf = SEED;
        for (int t = 0; t < T_RUN; t++) begin
            if (t < INIT_CYCLES) begin
                din_m[t] = INIT_VEC;
            end else if (t < INIT_CYCLES + PATTERNS) begin
                din_m[t] = lf[2:0];
                lf = mstep(lf);
            end else begin
                din_m[t] = 3'b000;
            end
        end
        for (int t = 0; t <= T_RUN; t++) begin
            if (echo && t >= CAPTURE_LAT) dout_m[t] = {3'b000, din_m[t-CAPTURE_LAT]};
            else dout_m[t] = 6'($urandom);
        end
        sig = 16'h0000;
        for (int k = 0; k < PATTERNS; k++) begin
            sig = mstep(sig) ^ {10'b0, dout_m[INIT_CYCLES+k+CAPTURE_LAT]};
        end
        gold = good_gold ? sig : (sig ^ (16'($urandom) | 16'h0001));
        last = (stop_at >= 0) ? stop_at : T_RUN - 1;
        for (int t = 0; t <= last; t++) exp_q.push_back('{K_CYC, din_m[t], 16'h0, 1'b0});
        if (stop_at >= 0) exp_q.push_back('{K_ABT, 3'b000, 16'h0, 1'b0});
        else exp_q.push_back('{K_DONE, 3'b000, sig, (sig == gold)});

        start  = 1'b1;
        golden = gold;
        @(posedge CK); #1;
        for (int t = 0; t <= T_RUN + 2; t++) begin
            dut_out = (t <= T_RUN) ? dout_m[t] : 6'($urandom);
            start   = noise && (stop_at < 0) && (t == 6);
            abort   = (t == stop_at) && !use_rst;
            RST     = (t == stop_at) && use_rst;
            if (t >= T_RUN) golden = 16'($urandom);
            if (use_rst && t == stop_at + 1) check("rst_signature", 32'(signature), 32'(0));
            @(posedge CK); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        RST   = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input bit pulse_abort);
        for (int i = 0; i < n; i++) begin
            abort   = pulse_abort && (i == 1);
            dut_out = 6'($urandom);
            golden  = 16'($urandom);
            @(posedge CK); #1;
        end
        abort = 1'b0;
    endtask

    initial begin
        RST     = 1'b1;
        start   = 1'b1;
        abort   = 1'b0;
        golden  = 16'h0000;
        dut_out = 6'h00;
        repeat (3) @(posedge CK);
        #1;
        check("rst_signature0", 32'(signature), 32'(0));
        check("rst_busy", 32'({busy, done, dut_in}), 32'(0));
        RST   = 1'b0;
        start = 1'b0;
        idle_cycles(3, 1'b0);
        check("post_rst_idle", 32'(busy), 32'(0));

        do_run(1'b1, 1'b1, -1, 1'b0, 1'b0);
        do_run(1'b1, 1'b1, -1, 1'b0, 1'b0);
        do_run(1'b0, 1'b1, -1, 1'b0, 1'b1);
        do_run(1'b0, 1'b0, -1, 1'b0, 1'b0);
        idle_cycles(4, 1'b1);
        do_run(1'b1, 1'b1, INIT_CYCLES + 1, 1'b0, 1'b0);
        idle_cycles(3, 1'b1);
        do_run(1'b1, 1'b1, -1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            do_run(1'($urandom), 1'($urandom), int'($urandom_range(0, T_RUN - 1)), (i == 2), 1'b0);
            idle_cycles(2, 1'b0);
            do_run(1'($urandom), 1'($urandom), -1, 1'b0, 1'($urandom));
        end
        do_run(1'b0, 1'b1, T_RUN - 1, 1'b0, 1'b0);
        do_run(1'b1, 1'b0, -1, 1'b0, 1'b0);
        idle_cycles(4, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
